// File: rtl/fazyrv_rf_seq.sv
// Chunk-serial register file: a transfer rotates the latched rs1/rs2/rd registers right by CHUNKSIZE
// per step for 32/CHUNKSIZE steps, with done_o one cycle after the last step and hold_i freezing it; FAZYRV_RF_DBG_EN adds dbg_res_o.
module fazyrv_rf_seq #(
  parameter int CHUNKSIZE = 2,
  parameter int NREGS     = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  input  logic                 start_i,
  input  logic                 hold_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [4:0]           rd_i,
  input  logic                 we_i,
  input  logic [CHUNKSIZE-1:0] res_i,
  output logic [CHUNKSIZE-1:0] ra_o,
  output logic [CHUNKSIZE-1:0] rb_o,
  output logic                 busy_o,
`ifdef FAZYRV_RF_DBG_EN
  output logic [31:0]          dbg_res_o,
`endif
  output logic                 done_o
);

  localparam int NSTEPS = 32 / CHUNKSIZE;
  localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam int AW     = $clog2(NREGS);
  localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_rs1;
  logic [AW-1:0]    r_rs2;
  logic [AW-1:0]    r_rd;
  logic             r_we;
  logic             r_done;
  logic [31:0]      r_regs [NREGS];
  logic [31:0]      w_next [NREGS];
  logic [NREGS-1:0] w_sel;
  logic             w_start;
  logic             w_step;
  logic             w_last;
  logic             w_unused;

  // The upper address bit is dropped when only 16 registers exist.
  assign w_unused = ^{rs1_i, rs2_i, rd_i};
  assign w_last   = (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_RUN;
          w_start     = 1'b1;
        end
      end
      S_RUN: begin
        if (!hold_i) begin
          w_step = 1'b1;
          if (w_last) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_step && w_last;
      if (w_start) begin
        r_cnt <= '0;
        r_rs1 <= rs1_i[AW-1:0];
        r_rs2 <= rs2_i[AW-1:0];
        r_rd  <= rd_i[AW-1:0];
        r_we  <= we_i;
      end else if (w_step) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Per-register next value; aliased addresses collapse onto one rotation.
  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    if (g == 0) begin : g_zero
      assign w_sel[g]  = 1'b0;
      assign w_next[g] = '0;
    end else begin : g_live
      localparam logic [AW-1:0] IDX = AW'(g);
      logic [CHUNKSIZE-1:0] w_in;
      assign w_sel[g] = (r_rs1 == IDX) || (r_rs2 == IDX) || (r_rd == IDX);
      assign w_in     = (r_we && (r_rd == IDX)) ? res_i : r_regs[g][CHUNKSIZE-1:0];
      if (CHUNKSIZE == 32) begin : g_full
        assign w_next[g] = w_in;
      end else begin : g_rot
        assign w_next[g] = {w_in, r_regs[g][31:CHUNKSIZE]};
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NREGS; i++) begin
      if (w_step && w_sel[i]) r_regs[i] <= w_next[i];
    end
  end

  assign ra_o   = (r_rs1 == '0) ? '0 : r_regs[r_rs1][CHUNKSIZE-1:0];
  assign rb_o   = (r_rs2 == '0) ? '0 : r_regs[r_rs2][CHUNKSIZE-1:0];
  assign busy_o = (r_state == S_RUN);
  assign done_o = r_done;

`ifdef FAZYRV_RF_DBG_EN
  assign dbg_res_o = (r_rd == '0) ? '0 : r_regs[r_rd];
`endif

endmodule

// File: doc/fazyrv_rf_seq.md
FAZYRV_RF_SEQ -- requirements
Module: fazyrv_rf_seq

Interface
REQ-001 Parameter CHUNKSIZE, default 2, data path width in bits; legal values 1, 2, 4, 8, 16, 32.
REQ-002 Parameter NREGS, default 32, number of architectural registers; legal values 16 (RVE) and 32 (RVI).
REQ-003 clk_i  input  1  clock; the block is sensitive to the rising edge only.
REQ-004 rst_in  input  1  reset; asynchronous and active-low.
REQ-005 start_i  input  1  request for one full-register transfer; sampled only in IDLE.
REQ-006 hold_i  input  1  stalls the transfer in RUN: no shift and no counter advance.
REQ-007 rs1_i, rs2_i, rd_i  input  5 each  register addresses; latched on start.
REQ-008 we_i  input  1  write enable for rd; latched on start.
REQ-009 res_i  input  CHUNKSIZE  write data chunk for the current step.
REQ-010 ra_o, rb_o  output  CHUNKSIZE each  current chunk of latched rs1 and rs2.
REQ-011 busy_o  output  1  high while in RUN.
REQ-012 done_o  output  1  one-cycle pulse after the final step.

Function
REQ-013 The block shall hold NREGS registers of 32 bits; x0 shall read zero and ignore writes.
REQ-014 The FSM shall have two states: IDLE and RUN.
REQ-015 IDLE->RUN shall occur when start_i=1. On that edge the block shall latch rs1_i, rs2_i, rd_i and we_i, and shall load the step counter with 0.
REQ-016 In RUN each cycle with hold_i=0 is one step. N = 32/CHUNKSIZE steps make up a transfer.
REQ-017 RUN->IDLE shall occur on the edge of step N-1. done_o shall be registered high for exactly the following cycle.
REQ-018 start_i shall be ignored while in RUN, including the cycle of the last step.
REQ-019 start_i shall be accepted in the cycle where done_o=1, which is an IDLE cycle.
REQ-020 On each step, only the registers addressed by latched rs1, rs2 and rd shall rotate right by CHUNKSIZE. All other registers shall hold their value.
REQ-021 On a step where latched we=1 and rd!=0, the chunk entering the MSB position of rd shall be res_i. Otherwise the rotated-out LSB chunk shall re-enter the MSB position.
REQ-022 ra_o and rb_o shall combinationally show bits [CHUNKSIZE-1:0] of the latched rs1 and rs2 registers, or zero for address 0, in every state. Chunks are transferred LSB first.
REQ-023 Aliased addresses shall rotate the shared register once per step. For rd==rs1 or rd==rs2, ra_o/rb_o shall show the pre-step chunk, i.e. the old value.
REQ-024 After N steps with we=0, every register shall equal its value before the transfer.
REQ-025 For NREGS=16, address bit 4 shall be ignored, so address 17 aliases to address 1.
REQ-026 The step counter shall be $clog2(N) bits wide, with a minimum of 1 bit. For CHUNKSIZE=32 a transfer is a single step.
REQ-027 With hold_i=1 in RUN, the counter, the registers and ra_o/rb_o shall all be stable.

Reset
REQ-028 On rst_in=0 the FSM shall go to IDLE, and the counter and the latched address and we registers shall clear to 0.
REQ-029 While in reset, busy_o=0, done_o=0, ra_o=0 and rb_o=0.
REQ-030 Register storage shall not be reset. After reset asserted mid-transfer, the contents of the latched rs1, rs2 and rd registers are unspecified; all other registers keep their values.
REQ-031 Reset release shall be followed by IDLE. No done_o shall be generated for an aborted transfer.

Configuration
REQ-032 Macro FAZYRV_RF_DBG_EN shall control a debug output.
- Defined: add output dbg_res_o, 32 bits, equal to the full contents of the latched rd register; it is valid in the done_o cycle, and zero when rd=0.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

Verification
REQ-033 Write test: CHUNKSIZE=2; start with rd=5, we=1; feed res_i 16 chunks of 0xDEADBEEF LSB first. Then start with rs1=5, we=0. Required: ra_o sequence reassembles 0xDEADBEEF, done_o pulses once per transfer, and each transfer is 17 cycles from start to done.
REQ-034 x0 test: start with rd=0, we=1, res_i all ones; then read rs1=0. Required: ra_o=0 on every step.
REQ-035 Hazard test: rd=rs1=rs2=3 holding 0x12345678; write 0xCAFEF00D. Required: ra_o and rb_o stream 0x12345678, and a subsequent read returns 0xCAFEF00D.
REQ-036 Hold test: assert hold_i for 5 cycles at step 4. Required: outputs stable during hold, done_o delayed by exactly 5 cycles, data intact.
REQ-037 Reset test: assert rst_in at step 7, then start again on x9. Required: busy_o=0 and no done_o after the abort; unaddressed register x9 retains its value.
REQ-038 Parameter sweep: NREGS=16 with address 17. Required: reads and writes alias to x1. With FAZYRV_RF_DBG_EN defined, dbg_res_o equals the written value in the done_o cycle.
